// File: rtl/mips_sram_pkg.sv
// Shared encodings and constants for the SRAM-like data-port responder
// and its optional pseudo-random latency generator.
package mips_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 mapped onto q[15], q[13], q[12], q[10]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int CNT_W      = 4;
    localparam int DEF_MEM_AW = 12;

endpackage

// File: rtl/data_sram_responder_lfsr16.sv
// 16-bit Fibonacci LFSR used to jitter the responder latency; only built
// when RESP_RANDOM_DELAY_EN is defined.
`ifdef RESP_RANDOM_DELAY_EN
module lfsr16
    import mips_sram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule
`endif

// File: rtl/data_sram_responder.sv
// SRAM-like data-port responder with programmable latency and byte-enabled writes.
// Define RESP_RANDOM_DELAY_EN to add 0..3 extra pseudo-random WAIT cycles per transaction.
module data_sram_responder
    import mips_sram_pkg::*;
#(
    parameter int MEM_AW  = DEF_MEM_AW,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int DEPTH = 1 << MEM_AW;
    // One bit of headroom so LATENCY-1 plus the random extra (max 3) cannot wrap.
    localparam logic [CNT_W:0] CNT_LOAD = (CNT_W + 1)'(LATENCY - 1);

    state_t              state;
    logic [CNT_W:0]      cnt;
    logic [CNT_W:0]      cnt_load;
    logic                handshake;
    logic                access;

    logic                wr_q;
    logic [MEM_AW-1:0]   idx_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         wdata_q;

    logic [31:0]         mem [DEPTH];

    logic                unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:MEM_AW+2], addr[1:0]};

`ifdef RESP_RANDOM_DELAY_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr_bits;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q[15:2];
    assign cnt_load = CNT_LOAD + {{(CNT_W - 1){1'b0}}, lfsr_q[1:0]};
`else
    assign cnt_load = CNT_LOAD;
`endif

    assign addr_ok   = rst && ((state == IDLE) || (state == RESP));
    assign handshake = req && addr_ok;
    assign access    = (state == WAIT) && (cnt == '0);

    // Request capture: sampled only on handshake, otherwise inputs are ignored.
    always_ff @(posedge clk) begin
        if (handshake) begin
            wr_q    <= wr;
            idx_q   <= addr[MEM_AW+1:2];
            wstrb_q <= wstrb;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (access && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // rdata captures the word on every access, so a write returns the pre-write content.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
        end else begin
            data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        cnt   <= cnt_load;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rdata   <= mem[idx_q];
                        data_ok <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (handshake) begin
                        cnt   <= cnt_load;
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU's SRAM-like data port.
- Accepts one request per handshake: read, or byte-enabled write.
- Serves it from an internal word-addressed array after a programmable latency, then returns `data_ok` with read data.
- Sits opposite the core's data master in simulation and FPGA test top-levels; it replaces the zero-latency ideal SRAM so stall and handshake paths get exercised.

Parameters:
MEM_AW, 12, log2 of array depth in 32-bit words (4096 words = 16 KiB)
LATENCY, 2, cycles spent in WAIT per transaction; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  1  request valid from master
wr  in  1  1 = write, 0 = read; sampled on handshake
addr  in  32  byte address; only addr[MEM_AW+1:2] used
wstrb  in  4  byte enables for writes; bit i covers wdata[8i+7:8i]
wdata  in  32  write data, already lane-aligned by master
addr_ok  out  1  request accepted this cycle when req & addr_ok
data_ok  out  1  one-cycle pulse; transaction complete
rdata  out  32  read data, valid while data_ok = 1

Behaviour:
- Reset (rst = 0, async): state = IDLE, data_ok = 0, rdata = 0, counter = 0. The memory array is not reset.
- `addr_ok` is combinational: 1 in IDLE and RESP, 0 in WAIT and while rst = 0.
- Handshake occurs on a rising edge with req & addr_ok. On handshake, latch wr, addr index, wstrb and wdata; load counter with LATENCY-1; next state is WAIT.
- IDLE: on handshake go to WAIT; otherwise stay.
- WAIT:
  - counter != 0: decrement and stay.
  - counter == 0: perform the access on this edge, then go to RESP.
    - Write: each array byte with wstrb[i] = 1 is updated; the other bytes are untouched.
    - Read: the array word is registered into rdata.
    - Write with wstrb = 0: no array change; still completes.
- RESP: data_ok = 1 for exactly this cycle. On a simultaneous handshake go to WAIT (back-to-back); otherwise go to IDLE.
- rdata on write completion: holds the pre-write content of the addressed word (read-before-write at the same edge).
- rdata holds its last value outside RESP; data_ok is never asserted outside RESP.
- Latency: a handshake in cycle t gives data_ok in cycle t+LATENCY+1. Sustained throughput is one transaction per LATENCY+1 cycles.
- Ordering: strictly in order, at most one outstanding transaction. A read after a write to the same word returns the written bytes.
- Address: addr[1:0] and addr[31:MEM_AW+2] are ignored, so accesses wrap modulo the array size. Alignment checking is the master's responsibility.
- Input stability: req/wr/addr/wstrb/wdata are only sampled on handshake; changes while addr_ok = 0 are ignored.
- Reset mid-transaction: the in-flight transaction is dropped and data_ok is not issued. Array contents remain whatever the last completed write left.

Optional Feature:
- Macro: RESP_RANDOM_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) runs every cycle; it is seeded to 16'hACE1 on reset.
  - On handshake the counter loads LATENCY-1 + lfsr[1:0], giving a WAIT length of LATENCY..LATENCY+3, pseudo-random and reproducible.
- Not defined: no LFSR logic; the fixed latency above applies exactly.

Decomposition:
- Shared package/header mips_sram_pkg contains:
  - state encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2
  - LFSR_SEED = 16'hACE1 and the tap mask
  - counter width constant CNT_W = 4
  - default MEM_AW
- One sub-module, lfsr16 (clk, rst, en, q[15:0]), instantiated only under RESP_RANDOM_DELAY_EN.
- The memory array and byte-merge logic stay inline.

Test Plan:
- Reset: assert rst = 0 mid-WAIT → data_ok = 0, rdata = 0 immediately; after release addr_ok = 1 and no stray data_ok.
- Write/read basic: write addr 0x0000_0010, wdata 0xDEADBEEF, wstrb 4'hF, LATENCY = 2; then read 0x10 → data_ok exactly 3 cycles after each handshake, read rdata = 0xDEADBEEF.
- Byte strobes: preload 0x11223344 at 0x20; write wdata 0xAABBCCDD with wstrb 4'b0101; read → 0x11BB33DD. Write with wstrb 0 → word unchanged, data_ok still pulses.
- Back-to-back: req held high for 4 reads at 0x0, 0x4, 0x8, 0xC → handshakes every LATENCY+1 = 3 cycles, four data_ok pulses in order with matching words, addr_ok = 0 in every WAIT cycle.
- Wrap: MEM_AW = 12, write 0x5A5A5A5A to 0x0000_4004; read 0x0000_0004 → 0x5A5A5A5A. addr[1:0] = 2'b11 reads the same word.
- RESP_RANDOM_DELAY_EN defined: 200 random reads/writes against a scoreboard model → data_ok gap after handshake always within [LATENCY+1, LATENCY+4], all data correct, and the delay sequence identical across two runs.
